result_reader: RTL



---
 rtl/mm_pkg.sv | 20 ++
 rtl/result_reader_if.sv | 26 ++
 rtl/result_fifo.sv | 44 ++++
 rtl/result_reader.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared constants, reader state type and the word-to-address mapping used by
// the matrix-multiply result path.
package mm_pkg;

  localparam int N      = 16;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } reader_state_t;

  // Row-major word k lives at address k; column-major walks C transposed.
  function automatic int unsigned word_addr(int unsigned k, int unsigned n, bit transpose);
    return transpose ? (k % n) * n + k / n : k;
  endfunction

endpackage

// File: rtl/result_reader_if.sv
// BRAM C read ports plus the outgoing valid/ready result stream.
interface result_reader_if #(
  parameter int ADDR_W = mm_pkg::ADDR_W,
  parameter int DATA_W = mm_pkg::DATA_W
) ();

  logic [ADDR_W-1:0] bram_c_addr_a;
  logic [ADDR_W-1:0] bram_c_addr_b;
  logic [DATA_W-1:0] bram_c_q_a;
  logic [DATA_W-1:0] bram_c_q_b;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output bram_c_addr_a, bram_c_addr_b, out_data, out_valid, out_last,
    input  bram_c_q_a, bram_c_q_b, out_ready
  );

  modport slave (
    input  bram_c_addr_a, bram_c_addr_b, out_data, out_valid, out_last,
    output bram_c_q_a, bram_c_q_b, out_ready
  );

endinterface

// File: rtl/result_fifo.sv
// Small FIFO accepting up to two words per cycle (A then B) and popping one;
// the head word is read straight from registered storage.
module result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_a,
  input  logic                     wr_en_b,
  input  logic [DATA_W-1:0]        wr_data_a,
  input  logic [DATA_W-1:0]        wr_data_b,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int unsigned DEPTH_U = DEPTH;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     wr_ptr_b;
  logic [PW-1:0]     rd_ptr;

  assign wr_ptr_b = wr_en_a ? wr_ptr + PW'(1) : wr_ptr;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en_a) mem[wr_ptr] <= wr_data_a;
      if (wr_en_b) mem[wr_ptr_b] <= wr_data_b;
      wr_ptr <= wr_ptr + PW'(wr_en_a) + PW'(wr_en_b);
      rd_ptr <= rd_ptr + PW'(rd_en);
      count  <= count + (PW+1)'(wr_en_a) + (PW+1)'(wr_en_b) - (PW+1)'(rd_en);
    end
  end

endmodule

// File: rtl/result_reader.sv
// Drains the N*N result matrix from BRAM C as a valid/ready word stream.
// Define RESULT_READER_TRANSPOSE_EN to stream C column-major instead of row-major.
module result_reader #(
  parameter int N          = mm_pkg::N,
  parameter int ADDR_W     = mm_pkg::ADDR_W,
  parameter int DATA_W     = mm_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  result_reader_if.master bus
);

  import mm_pkg::*;

  localparam int WORDS = N * N;
  localparam int KW    = $clog2(WORDS + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DEPTH_U = FIFO_DEPTH;
`ifdef RESULT_READER_TRANSPOSE_EN
  localparam bit TRANSPOSE = 1'b1;
`else
  localparam bit TRANSPOSE = 1'b0;
`endif

  reader_state_t     state, state_next;
  logic [KW-1:0]     issue_k;
  logic [KW-1:0]     out_idx;
  logic              iss1, iss2;
  logic              done_q;
  logic              issue, pop, last_word, last_pair;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] head;
  logic [ADDR_W-1:0] addr_a, addr_b;
  int unsigned       in_use;

  assign pop       = bus.out_valid && bus.out_ready;
  assign last_word = (out_idx == KW'(WORDS - 1));
  assign last_pair = (issue_k == KW'(WORDS - 2));

  assign bus.out_valid     = (fifo_count != '0);
  assign bus.out_last      = bus.out_valid && last_word;
  assign bus.out_data      = head;
  assign bus.bram_c_addr_a = addr_a;
  assign bus.bram_c_addr_b = addr_b;
  assign busy              = (state != IDLE);
  assign done              = done_q;

  // Credits cover both BRAM latency stages; the same-cycle pop is counted back
  // so a single stream keeps one word per cycle with only four entries.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    in_use     = 32'(fifo_count) + (iss1 ? 32'd2 : 32'd0) + (iss2 ? 32'd2 : 32'd0);
    unique case (state)
      IDLE: begin
        if (start && !done_q) begin
          issue      = 1'b1;
          state_next = last_pair ? DRAIN : READ;
        end
      end
      READ: begin
        if (in_use + 32'd2 <= DEPTH_U + (pop ? 32'd1 : 32'd0)) begin
          issue = 1'b1;
          if (last_pair) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_word) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_k <= '0;
      out_idx <= '0;
      iss1    <= 1'b0;
      iss2    <= 1'b0;
      done_q  <= 1'b0;
      addr_a  <= '0;
      addr_b  <= '0;
    end else begin
      iss1   <= issue;
      iss2   <= iss1;
      done_q <= (state == DRAIN) && pop && last_word;
      if (issue) begin
        addr_a  <= ADDR_W'(word_addr(32'(issue_k), N, TRANSPOSE));
        addr_b  <= ADDR_W'(word_addr(32'(issue_k) + 32'd1, N, TRANSPOSE));
        issue_k <= last_pair ? '0 : issue_k + KW'(2);
      end
      if (pop) out_idx <= last_word ? '0 : out_idx + KW'(1);
    end
  end

  result_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_a   (iss2),
    .wr_en_b   (iss2),
    .wr_data_a (bus.bram_c_q_a),
    .wr_data_b (bus.bram_c_q_b),
    .rd_en     (pop),
    .rd_data   (head),
    .count     (fifo_count)
  );

endmodule
